addsub_pipe_param: RTL and testbench

//  Parametrised pipelined integer add/sub primitive for HT personality datapaths.
//  - Carries a hardware-thread ID tag and a valid bit alongside each result.
//  - Adds per-op mode select (add, sub, unsigned/signed saturating add) and an overflow flag.
//  - Adds global stall, flush and an in-flight occupancy count.
//  - Drop-in successor for fixed-latency adder prims; LAT=5, op=00 matches the legacy 5-stage add.

---
 rtl/addsub_pipe_param.sv | 149 ++++++++++++++
 tb/tb_addsub_pipe_param.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_pipe_param.sv
// Pipelined add/sub/saturating-add primitive with thread tag, valid, stall, flush and
// an in-flight occupancy count. Latency is LAT edges when not stalled.
module addsub_pipe_param #(
  parameter int W      = 64,
  parameter int HTID_W = 7,
  parameter int LAT    = 5
) (
  input  logic                       ck,
  input  logic                       rst,
  input  logic [W-1:0]               i_a,
  input  logic [W-1:0]               i_b,
  input  logic [1:0]                 i_op,
  input  logic [HTID_W-1:0]          i_htId,
  input  logic                       i_vld,
  input  logic                       i_stall,
  input  logic                       i_flush,
  output logic [W-1:0]               o_res,
  output logic                       o_ovf,
  output logic [HTID_W-1:0]          o_htId,
  output logic                       o_vld,
  output logic [$clog2(LAT+1)-1:0]   o_cnt
);

  localparam int CNT_W = $clog2(LAT+1);

  logic [W:0]          add_full;
  logic [W:0]          sub_full;
  logic                sgn_ovf;
  logic                advance;
  logic [W-1:0]        res_d;
  logic                ovf_d;
  logic [CNT_W-1:0]    cnt_d;

  logic [LAT-1:0]      vld_q;
  logic [W-1:0]        res_q  [LAT];
  logic                ovf_q  [LAT];
  logic [HTID_W-1:0]   htid_q [LAT];
  logic [CNT_W-1:0]    cnt_q;

  // Stage-1 arithmetic and occupancy next-state
  always_comb begin
    add_full = {1'b0, i_a} + {1'b0, i_b};
    sub_full = {1'b0, i_a} - {1'b0, i_b};
    // Same-sign operands whose sum flips sign have left the signed range
    sgn_ovf  = (i_a[W-1] == i_b[W-1]) && (add_full[W-1] != i_a[W-1]);
    advance  = ~i_stall & ~i_flush;
    res_d    = add_full[W-1:0];
    ovf_d    = 1'b0;
    case (i_op)
      2'b00: begin
        res_d = add_full[W-1:0];
        ovf_d = add_full[W];
      end
      2'b01: begin
        res_d = sub_full[W-1:0];
        ovf_d = sub_full[W];
      end
      2'b10: begin
        if (add_full[W]) begin
          res_d = {W{1'b1}};
          ovf_d = 1'b1;
        end else begin
          res_d = add_full[W-1:0];
          ovf_d = 1'b0;
        end
      end
      2'b11: begin
        if (sgn_ovf) begin
          res_d = i_a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
          ovf_d = 1'b1;
        end else begin
          res_d = add_full[W-1:0];
          ovf_d = 1'b0;
        end
      end
      default: begin
        res_d = add_full[W-1:0];
        ovf_d = add_full[W];
      end
    endcase

    if (i_flush) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (advance) begin
      cnt_d = cnt_q + CNT_W'(i_vld) - CNT_W'(vld_q[LAT-1]);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Valid chain: cleared by flush, frozen by stall
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      vld_q <= {LAT{1'b0}};
    end else if (i_flush) begin
      vld_q <= {LAT{1'b0}};
    end else if (advance) begin
      vld_q[0] <= i_vld;
      for (int k = 1; k < LAT; k++) begin
        vld_q[k] <= vld_q[k-1];
      end
    end else begin
      vld_q <= vld_q;
    end
  end

  // Data chain shifts on every advance, independent of valid
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) begin
        res_q[k]  <= {W{1'b0}};
        ovf_q[k]  <= 1'b0;
        htid_q[k] <= {HTID_W{1'b0}};
      end
    end else if (advance) begin
      res_q[0]  <= res_d;
      ovf_q[0]  <= ovf_d;
      htid_q[0] <= i_htId;
      for (int k = 1; k < LAT; k++) begin
        res_q[k]  <= res_q[k-1];
        ovf_q[k]  <= ovf_q[k-1];
        htid_q[k] <= htid_q[k-1];
      end
    end else begin
      for (int k = 0; k < LAT; k++) begin
        res_q[k]  <= res_q[k];
        ovf_q[k]  <= ovf_q[k];
        htid_q[k] <= htid_q[k];
      end
    end
  end

  // Occupancy counter
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Valid is gated so a held result is never presented twice
  assign o_res  = res_q[LAT-1];
  assign o_ovf  = ovf_q[LAT-1];
  assign o_htId = htid_q[LAT-1];
  assign o_vld  = vld_q[LAT-1] & ~i_stall & ~i_flush;
  assign o_cnt  = cnt_q;

endmodule

// File: tb/tb_addsub_pipe_param.sv
// Scoreboard bench for addsub_pipe_param: a driver pushes model results at each accept edge,
// a negedge monitor pops and checks data, tag, latency and occupancy.
module tb_addsub_pipe_param;

  localparam int W      = 64;
  localparam int HTID_W = 7;
  localparam int LAT    = 5;
  localparam int CNT_W  = $clog2(LAT+1);

  typedef struct {
    logic [W-1:0]      res;
    logic              ovf;
    logic [HTID_W-1:0] tag;
    int                acc;
    int                st;
  } exp_t;

  logic              ck;
  logic              rst;
  logic [W-1:0]      i_a;
  logic [W-1:0]      i_b;
  logic [1:0]        i_op;
  logic [HTID_W-1:0] i_htId;
  logic              i_vld;
  logic              i_stall;
  logic              i_flush;
  logic [W-1:0]      o_res;
  logic              o_ovf;
  logic [HTID_W-1:0] o_htId;
  logic              o_vld;
  logic [CNT_W-1:0]  o_cnt;

  exp_t q[$];
  int   n_cmp;
  int   n_bad;
  int   cyc;
  int   stall_cnt;

  addsub_pipe_param #(.W(W), .HTID_W(HTID_W), .LAT(LAT)) dut (
    .ck(ck), .rst(rst), .i_a(i_a), .i_b(i_b), .i_op(i_op), .i_htId(i_htId),
    .i_vld(i_vld), .i_stall(i_stall), .i_flush(i_flush),
    .o_res(o_res), .o_ovf(o_ovf), .o_htId(o_htId), .o_vld(o_vld), .o_cnt(o_cnt)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic using true (unbounded) integer values
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [1:0] op, input logic [HTID_W-1:0] tag);
    exp_t e;
    logic [W:0]          u;
    logic [W:0]          umax;
    logic signed [W+1:0] s;
    logic signed [W+1:0] smax;
    logic signed [W+1:0] smin;
    u    = {1'b0, a} + {1'b0, b};
    umax = {1'b0, {W{1'b1}}};
    s    = $signed({{2{a[W-1]}}, a}) + $signed({{2{b[W-1]}}, b});
    smax = $signed({3'b000, {(W-1){1'b1}}});
    smin = -smax - $signed({{(W+1){1'b0}}, 1'b1});
    e.tag = tag;
    e.acc = 0;
    e.st  = 0;
    case (op)
      2'd0: begin e.res = a + b; e.ovf = (u > umax); end
      2'd1: begin e.res = a - b; e.ovf = (a < b); end
      2'd2: begin
        if (u > umax) begin e.res = {W{1'b1}}; e.ovf = 1'b1; end
        else begin e.res = u[W-1:0]; e.ovf = 1'b0; end
      end
      default: begin
        if (s > smax) begin e.res = smax[W-1:0]; e.ovf = 1'b1; end
        else if (s < smin) begin e.res = smin[W-1:0]; e.ovf = 1'b1; end
        else begin e.res = s[W-1:0]; e.ovf = 1'b0; end
      end
    endcase
    return e;
  endfunction

  // One clock edge with scoreboard bookkeeping; inputs change 1 time unit later
  task automatic tick();
    exp_t e;
    @(posedge ck);
    cyc++;
    if (rst) begin
      q.delete();
    end else if (i_flush) begin
      q.delete();
    end else if (i_stall) begin
      stall_cnt++;
    end else if (i_vld) begin
      e     = model(i_a, i_b, i_op, i_htId);
      e.acc = cyc;
      e.st  = stall_cnt;
      q.push_back(e);
    end
    #1;
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [1:0] op, input logic [HTID_W-1:0] tag);
    i_a = a; i_b = b; i_op = op; i_htId = tag; i_vld = 1'b1;
    tick();
    i_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    i_vld = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0: v = {W{1'b1}};
      1: v = {W{1'b0}};
      2: v = {1'b0, {(W-1){1'b1}}};
      3: v = {1'b1, {(W-1){1'b0}}};
      4: v = {{(W-1){1'b0}}, 1'b1};
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  // Monitor: pop on every presented result, check latency, missing outputs and occupancy
  always @(negedge ck) begin
    exp_t e;
    int   el;
    chk("cnt_vs_inflight", 128'(o_cnt), 128'(q.size()));
    if (o_vld) begin
      if (q.size() == 0) begin
        chk("unexpected_vld", 128'(o_vld), 128'd0);
      end else begin
        e  = q.pop_front();
        el = cyc - e.acc - (stall_cnt - e.st);
        chk("res", 128'(o_res), 128'(e.res));
        chk("ovf", 128'(o_ovf), 128'(e.ovf));
        chk("htId", 128'(o_htId), 128'(e.tag));
        chk("latency", 128'(el), 128'(LAT - 1));
      end
    end else if (!rst && !i_stall && !i_flush && q.size() > 0) begin
      el = cyc - q[0].acc - (stall_cnt - q[0].st);
      if (el >= LAT - 1) chk("missing_vld", 128'(o_vld), 128'd1);
    end
  end

  initial begin
    logic [W-1:0] ones;
    logic [W-1:0] smaxv;
    logic [W-1:0] sminv;
    logic         st;
    ones  = {W{1'b1}};
    smaxv = {1'b0, {(W-1){1'b1}}};
    sminv = {1'b1, {(W-1){1'b0}}};
    n_cmp = 0; n_bad = 0; cyc = 0; stall_cnt = 0;
    rst = 1'b1; i_a = '0; i_b = '0; i_op = 2'd0; i_htId = '0;
    i_vld = 1'b0; i_stall = 1'b0; i_flush = 1'b0;
    tick();
    chk("rst_vld", 128'(o_vld), 128'd0);
    chk("rst_res", 128'(o_res), 128'd0);
    chk("rst_ovf", 128'(o_ovf), 128'd0);
    chk("rst_htId", 128'(o_htId), 128'd0);
    chk("rst_cnt", 128'(o_cnt), 128'd0);
    tick();
    rst = 1'b0;
    idle(2);

    // Basic add and arithmetic corner cases
    issue(64'd3, 64'd4, 2'd0, 7'h11);
    issue(ones, 64'd1, 2'd0, 7'h21);
    issue(64'd1, 64'd2, 2'd1, 7'h22);
    issue(ones, 64'd1, 2'd2, 7'h23);
    issue(smaxv, 64'd1, 2'd3, 7'h31);
    issue(sminv, ones, 2'd3, 7'h32);
    issue(64'd5, ones, 2'd3, 7'h33);
    idle(LAT + 2);

    // Back-to-back with a 3-cycle stall
    issue(pick(), pick(), 2'd0, 7'd1);
    issue(pick(), pick(), 2'd1, 7'd2);
    i_stall = 1'b1;
    idle(3);
    i_stall = 1'b0;
    issue(pick(), pick(), 2'd2, 7'd3);
    issue(pick(), pick(), 2'd3, 7'd4);
    issue(pick(), pick(), 2'd0, 7'd5);
    chk("cnt_peak", 128'(o_cnt), 128'd5);
    idle(LAT + 2);

    // Flush with a fourth op in the flush cycle
    issue(pick(), pick(), 2'd0, 7'h41);
    issue(pick(), pick(), 2'd1, 7'h42);
    issue(pick(), pick(), 2'd2, 7'h43);
    i_flush = 1'b1;
    issue(pick(), pick(), 2'd3, 7'h44);
    i_flush = 1'b0;
    chk("cnt_after_flush", 128'(o_cnt), 128'd0);
    issue(64'd10, 64'd20, 2'd0, 7'h45);
    idle(LAT + 2);

    // Asynchronous reset mid-cycle
    issue(pick(), pick(), 2'd0, 7'h51);
    issue(pick(), pick(), 2'd0, 7'h52);
    idle(LAT - 2);
    #2;
    rst = 1'b1;
    q.delete();
    #1;
    chk("arst_vld", 128'(o_vld), 128'd0);
    chk("arst_cnt", 128'(o_cnt), 128'd0);
    chk("arst_res", 128'(o_res), 128'd0);
    chk("arst_htId", 128'(o_htId), 128'd0);
    tick();
    rst = 1'b0;
    idle(LAT + 2);

    // Randomized traffic with occasional stall and flush
    for (int i = 0; i < 400; i++) begin
      st      = ($urandom_range(0, 7) == 0);
      i_stall = st;
      i_flush = ($urandom_range(0, 39) == 0);
      i_a     = pick();
      i_b     = pick();
      i_op    = 2'($urandom_range(0, 3));
      i_htId  = HTID_W'($urandom);
      i_vld   = !st && ($urandom_range(0, 3) != 0);
      tick();
    end
    i_stall = 1'b0;
    i_flush = 1'b0;
    idle(LAT + 3);
    chk("drain_empty", 128'(q.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
